// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the buffered UART transmit path.
package uart_pkg;

   localparam int UART_DATA_WIDTH = 8;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   // Even parity of the byte, inverted when odd parity is selected.
   function automatic logic parity_bit(input logic [UART_DATA_WIDTH-1:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Synchronous byte FIFO with one-bit-extended pointers; a write is accepted
// while full when a read frees the head in the same cycle.
module sync_byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_i,
   input  logic [UART_DATA_WIDTH-1:0] wr_data_i,
   input  logic                       rd_i,
   output logic [UART_DATA_WIDTH-1:0] rd_data_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]                wr_ptr_q, wr_ptr_d;
   logic [AW:0]                rd_ptr_q, rd_ptr_d;
   logic [UART_DATA_WIDTH-1:0] mem_q [DEPTH];
   logic                       wr_en_s;
   logic                       rd_en_s;

   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign full_o    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign rd_en_s   = rd_i && !empty_o;
   assign wr_en_s   = wr_i && (!full_o || rd_en_s);
   assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

   // Next pointer values; wrap is free because of the extra MSB.
   always_comb begin
      wr_ptr_d = wr_en_s ? (wr_ptr_q + 1'b1) : wr_ptr_q;
      rd_ptr_d = rd_en_s ? (rd_ptr_q + 1'b1) : rd_ptr_q;
   end

   // Pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array, data only.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
      end
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: absorbs the fetcher's byte strobes in a FIFO and
// serialises them LSB first with optional parity and one or two stop bits.
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int BAUD_DIV    = 1085,
   parameter int FIFO_DEPTH  = 32,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS   = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [UART_DATA_WIDTH-1:0] tx_data,
   input  logic                       tx_wr,
   output logic                       tx_full,
   output logic                       tx_empty,
   output logic                       tx_busy,
   output logic                       overflow,
   input  logic                       ovf_clr,
   output logic                       tx
);

   localparam int             BW         = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [BW-1:0]  BAUD_LAST  = BW'(BAUD_DIV - 1);
   localparam logic [2:0]     STOP_LAST  = 3'(STOP_BITS - 1);
   localparam logic           HAS_PARITY = (PARITY_MODE != PARITY_NONE);
   localparam logic           PAR_ODD    = (PARITY_MODE == PARITY_ODD);

   tx_state_t                  state_q;
   logic [BW-1:0]              baud_q;
   logic [2:0]                 bit_q;
   logic [UART_DATA_WIDTH-1:0] shift_q;
   logic                       par_q;
   logic                       tx_q;
   logic                       busy_q;
   logic                       ovf_q;

   logic [UART_DATA_WIDTH-1:0] head_s;
   logic                       bit_end_s;
   logic                       stop_done_s;
   logic                       pop_s;
   logic                       drop_s;
   logic                       line_s;

   sync_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_i      (tx_wr),
      .wr_data_i (tx_data),
      .rd_i      (pop_s),
      .rd_data_o (head_s),
      .full_o    (tx_full),
      .empty_o   (tx_empty)
   );

   assign bit_end_s   = (baud_q == BAUD_LAST);
   assign stop_done_s = bit_end_s && (bit_q == STOP_LAST);
   assign drop_s      = tx_wr && tx_full && !pop_s;

   // Pop from IDLE, or at the very end of STOP so frames run back to back.
   always_comb begin
      pop_s = 1'b0;
      if (!tx_empty && ((state_q == IDLE) || ((state_q == STOP) && stop_done_s))) begin
         pop_s = 1'b1;
      end else begin
         pop_s = 1'b0;
      end
   end

   // Line level for the current state; registered into tx_q one edge later.
   always_comb begin
      line_s = 1'b1;
      case (state_q)
         IDLE:    line_s = 1'b1;
         START:   line_s = 1'b0;
         DATA:    line_s = shift_q[0];
         PARITY:  line_s = par_q;
         STOP:    line_s = 1'b1;
         default: line_s = 1'b1;
      endcase
   end

   // Transmit FSM with baud and bit counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= 3'd0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         tx_q   <= line_s;
         busy_q <= (state_q != IDLE);
         baud_q <= ((state_q == IDLE) || bit_end_s) ? '0 : (baud_q + 1'b1);
         case (state_q)
            IDLE: begin
               if (pop_s) begin
                  shift_q <= head_s;
                  par_q   <= parity_bit(head_s, PAR_ODD);
                  state_q <= START;
               end
            end
            START: begin
               if (bit_end_s) begin
                  bit_q   <= 3'd0;
                  state_q <= DATA;
               end
            end
            DATA: begin
               if (bit_end_s) begin
                  shift_q <= {1'b0, shift_q[UART_DATA_WIDTH-1:1]};
                  if (bit_q == 3'd7) begin
                     bit_q <= 3'd0;
                     if (HAS_PARITY) begin
                        state_q <= PARITY;
                     end else begin
                        state_q <= STOP;
                     end
                  end else begin
                     bit_q <= bit_q + 3'd1;
                  end
               end
            end
            PARITY: begin
               if (bit_end_s) begin
                  bit_q   <= 3'd0;
                  state_q <= STOP;
               end
            end
            STOP: begin
               if (stop_done_s) begin
                  bit_q <= 3'd0;
                  if (pop_s) begin
                     shift_q <= head_s;
                     par_q   <= parity_bit(head_s, PAR_ODD);
                     state_q <= START;
                  end else begin
                     state_q <= IDLE;
                  end
               end else if (bit_end_s) begin
                  bit_q <= bit_q + 3'd1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Sticky drop flag; a coincident drop beats the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (drop_s) begin
         ovf_q <= 1'b1;
      end else if (ovf_clr) begin
         ovf_q <= 1'b0;
      end
   end

   assign tx       = tx_q;
   assign tx_busy  = busy_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench: four DUT variants (no parity, even, odd, two stop bits),
// a frame vector table plus hand-written multi-cycle sequences.
module tb_uart_tx_buffered;

   localparam int BD = 4;
   localparam int FD = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] tx_data;
   logic [3:0] wr;
   logic       ovf_clr;
   logic [3:0] full_s, empty_s, busy_s, ovf_s, line_s;

   int errors = 0;
   int checks = 0;

   logic       exp_q[$];
   logic [7:0] data_q[$];

   typedef struct {
      int          unit;
      logic [7:0]  data;
      logic [11:0] bits;
      int          nbits;
   } vec_t;
   vec_t vecs[5];

   always #5 clk = ~clk;

   uart_tx_buffered #(.BAUD_DIV(BD), .FIFO_DEPTH(FD), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_wr(wr[0]), .tx_full(full_s[0]),
      .tx_empty(empty_s[0]), .tx_busy(busy_s[0]), .overflow(ovf_s[0]), .ovf_clr(ovf_clr), .tx(line_s[0]));
   uart_tx_buffered #(.BAUD_DIV(BD), .FIFO_DEPTH(FD), .PARITY_MODE(1), .STOP_BITS(1)) u1 (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_wr(wr[1]), .tx_full(full_s[1]),
      .tx_empty(empty_s[1]), .tx_busy(busy_s[1]), .overflow(ovf_s[1]), .ovf_clr(ovf_clr), .tx(line_s[1]));
   uart_tx_buffered #(.BAUD_DIV(BD), .FIFO_DEPTH(FD), .PARITY_MODE(2), .STOP_BITS(1)) u2 (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_wr(wr[2]), .tx_full(full_s[2]),
      .tx_empty(empty_s[2]), .tx_busy(busy_s[2]), .overflow(ovf_s[2]), .ovf_clr(ovf_clr), .tx(line_s[2]));
   uart_tx_buffered #(.BAUD_DIV(BD), .FIFO_DEPTH(FD), .PARITY_MODE(0), .STOP_BITS(2)) u3 (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_wr(wr[3]), .tx_full(full_s[3]),
      .tx_empty(empty_s[3]), .tx_busy(busy_s[3]), .overflow(ovf_s[3]), .ovf_clr(ovf_clr), .tx(line_s[3]));

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic push_bit(input logic b);
      for (int i = 0; i < BD; i++) exp_q.push_back(b);
   endtask

   // Expected line waveform of one frame, one entry per clock.
   task automatic push_frame(input logic [7:0] d, input int par, input int nstop);
      logic p;
      p = ^d;
      if (par == 2) p = ~p;
      push_bit(1'b0);
      for (int i = 0; i < 8; i++) push_bit(d[i]);
      if (par != 0) push_bit(p);
      for (int i = 0; i < nstop; i++) push_bit(1'b1);
   endtask

   // Writes data_q every 'step' cycles starting at t=0 and compares the line
   // against exp_q from t=3 (two edges after the first write) onward.
   task automatic run_seq(input int u, input int step, input int empty_from, input bit ovf_chk);
      int n;
      n = exp_q.size();
      for (int t = 0; t <= n + 3; t++) begin
         @(negedge clk);
         if (t >= 3 && t < n + 3) begin
            check("stream_tx", line_s[u], exp_q[t-3]);
            check("stream_busy", busy_s[u], 1'b1);
            check("stream_empty", empty_s[u], (t - 3) >= empty_from);
         end
         if (t == n + 3) begin
            check("seq_end_tx", line_s[u], 1'b1);
            check("seq_end_busy", busy_s[u], 1'b0);
            check("seq_end_empty", empty_s[u], 1'b1);
         end
         if (ovf_chk) begin
            if (t == 5) begin
               check("ovf_full", full_s[u], 1'b1);
               check("ovf_before_drop", ovf_s[u], 1'b0);
            end
            if (t == 6) check("ovf_set", ovf_s[u], 1'b1);
            if (t == 30) check("ovf_sticky", ovf_s[u], 1'b1);
            if (t == 31) check("ovf_cleared", ovf_s[u], 1'b0);
         end
         wr      = '0;
         ovf_clr = 1'b0;
         if ((t % step) == 0 && (t / step) < data_q.size()) begin
            wr[u]   = 1'b1;
            tx_data = data_q[t / step];
         end
         if (ovf_chk && t == 30) ovf_clr = 1'b1;
      end
      exp_q.delete();
      data_q.delete();
   endtask

   initial begin
      // {stop.., parity?, data, start} read LSB first
      vecs[0] = '{unit: 0, data: 8'hA5, bits: 12'h34A, nbits: 10};
      vecs[1] = '{unit: 1, data: 8'h07, bits: 12'h60E, nbits: 11};
      vecs[2] = '{unit: 2, data: 8'h07, bits: 12'h40E, nbits: 11};
      vecs[3] = '{unit: 3, data: 8'h3C, bits: 12'h678, nbits: 11};
      vecs[4] = '{unit: 1, data: 8'hFF, bits: 12'h5FE, nbits: 11};

      rst_n   = 1'b0;
      tx_data = 8'h00;
      wr      = 4'b0000;
      ovf_clr = 1'b0;
      repeat (3) @(negedge clk);
      for (int u = 0; u < 4; u++) begin
         check("rst_tx", line_s[u], 1'b1);
         check("rst_busy", busy_s[u], 1'b0);
         check("rst_empty", empty_s[u], 1'b1);
         check("rst_full", full_s[u], 1'b0);
         check("rst_ovf", ovf_s[u], 1'b0);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single frames from the vector table.
      for (int v = 0; v < 5; v++) begin
         int u;
         u = vecs[v].unit;
         @(negedge clk);
         tx_data = vecs[v].data;
         wr[u]   = 1'b1;
         @(negedge clk);
         wr = '0;
         check("write_tx_idle", line_s[u], 1'b1);
         check("write_queued", empty_s[u], 1'b0);
         @(negedge clk);
         check("pop_tx_idle", line_s[u], 1'b1);
         check("pop_busy", busy_s[u], 1'b0);
         check("pop_empty", empty_s[u], 1'b1);
         for (int b = 0; b < vecs[v].nbits; b++) begin
            for (int c = 0; c < BD; c++) begin
               @(negedge clk);
               check("frame_tx", line_s[u], vecs[v].bits[b]);
               check("frame_busy", busy_s[u], 1'b1);
            end
         end
         @(negedge clk);
         check("frame_end_tx", line_s[u], 1'b1);
         check("frame_end_busy", busy_s[u], 1'b0);
      end

      // Fetcher-style strobes every other cycle: back-to-back frames.
      data_q = '{8'h01, 8'h02, 8'h03};
      push_frame(8'h01, 0, 1);
      push_frame(8'h02, 0, 1);
      push_frame(8'h03, 0, 1);
      run_seq(0, 2, 79, 1'b0);

      // Six consecutive writes: one popped, four stored, sixth dropped.
      data_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
      for (int i = 0; i < 5; i++) push_frame(8'(8'h10 + i), 0, 1);
      run_seq(0, 1, 159, 1'b1);

      // Two stop bits: eight high cycles between frames.
      data_q = '{8'h55, 8'hAA};
      push_frame(8'h55, 0, 2);
      push_frame(8'hAA, 0, 2);
      run_seq(3, 1, 43, 1'b0);

      // Reset in the middle of DATA for 0xFF with two bytes queued.
      data_q = '{8'hFF, 8'h11, 8'h22};
      for (int t = 0; t < 13; t++) begin
         @(negedge clk);
         wr = '0;
         if (t < 3) begin
            wr[0]   = 1'b1;
            tx_data = data_q[t];
         end
      end
      data_q.delete();
      check("mid_busy", busy_s[0], 1'b1);
      check("mid_queued", empty_s[0], 1'b0);
      rst_n = 1'b0;
      #1;
      check("rst_mid_tx", line_s[0], 1'b1);
      check("rst_mid_busy", busy_s[0], 1'b0);
      check("rst_mid_empty", empty_s[0], 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_hold_tx", line_s[0], 1'b1);
         check("rst_hold_empty", empty_s[0], 1'b1);
         check("rst_hold_busy", busy_s[0], 1'b0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         check("post_rst_tx", line_s[0], 1'b1);
         check("post_rst_busy", busy_s[0], 1'b0);
      end

      // Reset during START must raise the line without a clock edge.
      @(negedge clk);
      tx_data = 8'h00;
      wr[0]   = 1'b1;
      @(negedge clk);
      wr = '0;
      repeat (2) @(negedge clk);
      check("start_low", line_s[0], 1'b0);
      rst_n = 1'b0;
      #1;
      check("rst_start_tx", line_s[0], 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("final_idle_tx", line_s[0], 1'b1);
      check("final_idle_busy", busy_s[0], 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
